// File: rtl/servcle_exit.sv
// rtl/servcle_exit.sv - servcle ring terminator: ring-to-stream FIFO and token owner
module servcle_exit #(
   parameter int DW      = 8,
   parameter int DEPTH   = 16,
   parameter int LAP_MAX = 8
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic [DW-1:0] i_data,
   input  logic          i_valid,
   input  logic          i_token,
   output logic          o_token,
   output logic [DW-1:0] o_data,
   output logic          o_valid,
   input  logic          i_ready,
   output logic          o_overflow,
   output logic          o_token_err
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   DEPTH_C   = DEPTH[AW:0];
   localparam logic [AW:0]   LAP_C     = LAP_MAX[AW:0];
   localparam logic [AW:0]   COUNT_ONE = 1;
   localparam logic [AW-1:0] PTR_ONE   = 1;

   typedef enum logic {HOLD, CIRC} state_t;

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [AW:0]   free;
   logic          pop;
   logic          push_ok;
   logic          overflow_q, overflow_d;
   logic          token_err_q, token_err_d;
   logic          token_q, token_d;
   state_t        state_q, state_d;

   // A full FIFO still accepts a word when the head leaves in the same cycle.
   assign pop     = (count_q != '0) & i_ready;
   assign push_ok = i_valid & ((count_q < DEPTH_C) | pop);
   assign free    = DEPTH_C - count_q;

   assign o_valid     = (count_q != '0);
   assign o_data      = mem_q[rd_ptr_q];
   assign o_token     = token_q;
   assign o_overflow  = overflow_q;
   assign o_token_err = token_err_q;

   // FIFO pointer/count next state and sticky error flags.
   always_comb begin
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q | (i_valid & ~push_ok);
      token_err_d = token_err_q | ((state_q == HOLD) & i_token);
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push_ok, pop})
         2'b10:   count_d = count_q + COUNT_ONE;
         2'b01:   count_d = count_q - COUNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Token FSM: release only when a whole lap of ring traffic is guaranteed to fit.
   always_comb begin
      state_d = state_q;
      token_d = 1'b0;
      case (state_q)
         HOLD: begin
            if (free >= LAP_C) begin
               token_d = 1'b1;
               state_d = CIRC;
            end
         end
         CIRC: begin
            if (i_token) state_d = HOLD;
         end
         default: state_d = HOLD;
      endcase
   end

   // FIFO storage; contents need no reset since count gates visibility.
   always_ff @(posedge i_clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= i_data;
   end

   // Control state registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         token_err_q <= 1'b0;
         token_q     <= 1'b0;
         state_q     <= HOLD;
      end else begin
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         token_err_q <= token_err_d;
         token_q     <= token_d;
         state_q     <= state_d;
      end
   end

endmodule

// File: tb/tb_servcle_exit.sv
// tb/tb_servcle_exit.sv - scoreboard bench for servcle_exit
module tb_servcle_exit;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b1;
   logic [7:0] i_data = '0;
   logic       i_valid = 1'b0;
   logic       i_token = 1'b0;
   logic       o_token;
   logic [7:0] o_data;
   logic       o_valid;
   logic       i_ready = 1'b0;
   logic       o_overflow;
   logic       o_token_err;

   int         vectors = 0;
   int         miscompares = 0;
   int         tok_cnt = 0;
   logic       prev_tok = 1'b0;
   logic [7:0] exp_q[$];

   servcle_exit #(.DW(8), .DEPTH(16), .LAP_MAX(8)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_valid(i_valid),
      .i_token(i_token), .o_token(o_token), .o_data(o_data), .o_valid(o_valid),
      .i_ready(i_ready), .o_overflow(o_overflow), .o_token_err(o_token_err)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Monitor: pops the scoreboard on every handshake and counts token pulses.
   always @(negedge i_clk) begin
      if (o_valid && i_ready) begin
         if (exp_q.size() == 0) chk("unexpected_word", 1, 0);
         else chk("data", o_data, exp_q.pop_front());
      end
      if (o_token) begin
         tok_cnt++;
         chk("tok_back_to_back", prev_tok, 0);
      end
      prev_tok = o_token;
   end

   task automatic push(input logic [7:0] w, input bit keep);
      i_valid = 1'b1;
      i_data  = w;
      if (keep) exp_q.push_back(w);
      tick();
      i_valid = 1'b0;
   endtask

   task automatic pulse_token();
      i_token = 1'b1;
      tick();
      i_token = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      i_ready = 1'b1;
      while (exp_q.size() != 0 && n < 100) begin
         tick();
         n++;
      end
      i_ready = 1'b0;
      chk("drain_empty", exp_q.size(), 0);
   endtask

   task automatic do_reset();
      i_ready = 1'b0;
      i_valid = 1'b0;
      i_rst   = 1'b1;
      tick();
      tick();
      exp_q.delete();
      i_rst = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;

      // Reset state and first token.
      repeat (3) begin
         @(posedge i_clk);
         @(negedge i_clk);
         chk("rst_token", o_token, 0);
         chk("rst_valid", o_valid, 0);
         chk("rst_ovf", o_overflow, 0);
         chk("rst_err", o_token_err, 0);
      end
      tick();
      i_rst = 1'b0;
      t0 = tok_cnt;
      tick();
      @(negedge i_clk);
      chk("first_token", o_token, 1);
      tick();
      @(negedge i_clk);
      chk("first_token_end", o_token, 0);
      repeat (5) tick();
      chk("first_token_once", tok_cnt - t0, 1);

      // Ordering with i_ready high.
      i_ready = 1'b1;
      push(8'h11, 1);
      @(negedge i_clk);
      chk("latency_valid", o_valid, 1);
      push(8'h22, 1);
      push(8'h33, 1);
      tick();
      tick();
      @(negedge i_clk);
      chk("order_valid_drop", o_valid, 0);
      chk("order_all_seen", exp_q.size(), 0);
      i_ready = 1'b0;

      // Backpressure gating of the token.
      for (int i = 0; i < 9; i++) push(8'h40 + 8'(i), 1);
      pulse_token();
      t0 = tok_cnt;
      repeat (5) tick();
      chk("gated_no_token", tok_cnt - t0, 0);
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      @(negedge i_clk);
      chk("gate_count8_no_token_yet", o_token, 0);
      tick();
      @(negedge i_clk);
      chk("gate_release", o_token, 1);
      drain();

      // Overflow: 17 pushes into a stalled FIFO.
      do_reset();
      for (int i = 0; i < 16; i++) push(8'h80 + 8'(i), 1);
      @(negedge i_clk);
      chk("ovf_at_full", o_overflow, 0);
      push(8'hEE, 0);
      @(negedge i_clk);
      chk("ovf_set", o_overflow, 1);
      drain();
      chk("ovf_sticky", o_overflow, 1);

      // Full FIFO with simultaneous pop accepts the 17th word.
      do_reset();
      for (int i = 0; i < 16; i++) push(8'hA0 + 8'(i), 1);
      i_ready = 1'b1;
      push(8'hB0, 1);
      i_ready = 1'b0;
      @(negedge i_clk);
      chk("full_pop_no_ovf", o_overflow, 0);
      drain();

      // Token error while held, then a single release after draining.
      do_reset();
      for (int i = 0; i < 16; i++) push(8'hC0 + 8'(i), 1);
      pulse_token();
      @(negedge i_clk);
      chk("err_first_return_ok", o_token_err, 0);
      pulse_token();
      @(negedge i_clk);
      chk("err_set", o_token_err, 1);
      t0 = tok_cnt;
      drain();
      repeat (10) tick();
      chk("err_single_release", tok_cnt - t0, 1);
      chk("err_sticky", o_token_err, 1);

      // Mid-operation reset.
      do_reset();
      for (int i = 0; i < 5; i++) push(8'hD0 + 8'(i), 1);
      i_rst = 1'b1;
      tick();
      exp_q.delete();
      i_rst = 1'b0;
      @(negedge i_clk);
      chk("midrst_valid", o_valid, 0);
      chk("midrst_token_low", o_token, 0);
      tick();
      @(negedge i_clk);
      chk("midrst_token", o_token, 1);
      i_ready = 1'b1;
      repeat (3) tick();
      @(negedge i_clk);
      chk("midrst_empty", o_valid, 0);
      i_ready = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
